// File: rtl/lzrw1_decompressor_top.sv
// Streaming LZRW1 decompressor: one literal or copy item in,
// one reconstructed byte out per cycle, backed by a circular history.
module lzrw1_decompressor_top #(
   parameter int HISTORY_SIZE = 256
) (
   input  logic        clock,
   input  logic        reset,
   input  logic [15:0] data_in,
   input  logic        control_word_in,
   input  logic        data_in_valid,
   output logic [7:0]  decompressed_byte,
   output logic        out_valid,
   output logic        decompressor_busy
);

   localparam int PW = $clog2(HISTORY_SIZE);

   typedef enum logic {
      IDLE,
      EMIT
   } state_t;

   state_t        state;
   state_t        state_nxt;

   logic [7:0]    history [HISTORY_SIZE];
   logic [PW-1:0] wr_ptr;
   logic [PW-1:0] offset_q;
   logic [PW-1:0] offset_nxt;
   logic [PW-1:0] item_offset;
   logic [PW-1:0] src_addr;
   logic [7:0]    rd_byte;
   logic [4:0]    remaining;
   logic [4:0]    remaining_nxt;
   logic [7:0]    byte_nxt;
   logic          valid_nxt;
   logic          wr_en;

   // The 12-bit offset field is split around the length nibble.
   assign item_offset = PW'({data_in[15:12], data_in[7:0]});

   // While idle the copy source comes straight from the new item.
   assign src_addr = wr_ptr -
      ((state == IDLE) ? item_offset : offset_q);

   assign rd_byte = history[src_addr];

   assign decompressor_busy = (state == EMIT);

   // Next-state, next-output and history write decision.
   always_comb begin
      state_nxt     = state;
      offset_nxt    = offset_q;
      remaining_nxt = remaining;
      byte_nxt      = decompressed_byte;
      valid_nxt     = 1'b0;
      wr_en         = 1'b0;
      unique case (state)
         IDLE: begin
            if (data_in_valid) begin
               state_nxt = EMIT;
               valid_nxt = 1'b1;
               wr_en     = 1'b1;
               if (control_word_in) begin
                  offset_nxt    = item_offset;
                  byte_nxt      = rd_byte;
                  remaining_nxt = 5'(data_in[11:8]) + 5'd2;
               end else begin
                  byte_nxt      = data_in[7:0];
                  remaining_nxt = 5'd0;
               end
            end
         end
         EMIT: begin
            if (remaining == 5'd0) begin
               state_nxt = IDLE;
            end else begin
               valid_nxt     = 1'b1;
               wr_en         = 1'b1;
               byte_nxt      = rd_byte;
               remaining_nxt = remaining - 5'd1;
            end
         end
         default: begin
            state_nxt = IDLE;
         end
      endcase
   end

   // Control and output registers.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state             <= IDLE;
         offset_q          <= '0;
         remaining         <= '0;
         decompressed_byte <= '0;
         out_valid         <= 1'b0;
         wr_ptr            <= '0;
      end else begin
         state             <= state_nxt;
         offset_q          <= offset_nxt;
         remaining         <= remaining_nxt;
         decompressed_byte <= byte_nxt;
         out_valid         <= valid_nxt;
         if (wr_en) begin
            wr_ptr <= wr_ptr + PW'(1);
         end
      end
   end

   // History: every emitted byte lands at wr_ptr.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         for (int i = 0; i < HISTORY_SIZE; i++) begin
            history[i] <= 8'h00;
         end
      end else if (wr_en) begin
         history[wr_ptr] <= byte_nxt;
      end
   end

endmodule

// File: tb/tb_lzrw1_decompressor_top.sv
// Randomized bench for lzrw1_decompressor_top against a
// byte-level LZRW1 reference model.
module tb_lzrw1_decompressor_top;

   localparam int N = 256;

   logic        clock;
   logic        reset;
   logic [15:0] data_in;
   logic        control_word_in;
   logic        data_in_valid;
   logic [7:0]  decompressed_byte;
   logic        out_valid;
   logic        decompressor_busy;

   int n_checks = 0;
   int n_fail   = 0;

   logic [7:0] hm [N];
   int         wp;
   logic [7:0] exp_q [$];

   lzrw1_decompressor_top #(.HISTORY_SIZE(N)) dut (
      .clock             (clock),
      .reset             (reset),
      .data_in           (data_in),
      .control_word_in   (control_word_in),
      .data_in_valid     (data_in_valid),
      .decompressed_byte (decompressed_byte),
      .out_valid         (out_valid),
      .decompressor_busy (decompressor_busy)
   );

   initial begin
      clock = 1'b0;
      forever #5 clock = ~clock;
   end

   task automatic check(input string tag,
                        input logic [31:0] got,
                        input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t",
                  tag, got, exp, $time);
      end
   endtask

   task automatic model_reset();
      for (int i = 0; i < N; i++) hm[i] = 8'h00;
      wp = 0;
      exp_q.delete();
   endtask

   task automatic model_push(input logic [7:0] b);
      hm[wp] = b;
      wp = (wp + 1) % N;
      exp_q.push_back(b);
   endtask

   task automatic model_item(input logic cw, input logic [15:0] d);
      int off;
      int len;
      if (!cw) begin
         model_push(d[7:0]);
      end else begin
         off = (int'(d[15:12]) * 256 + int'(d[7:0])) % N;
         len = int'(d[11:8]) + 3;
         for (int k = 0; k < len; k++)
            model_push(hm[(wp - off + N) % N]);
      end
   endtask

   task automatic scramble();
      data_in         = 16'($urandom);
      control_word_in = 1'($urandom);
      data_in_valid   = 1'($urandom);
   endtask

   task automatic idle(input int k);
      data_in_valid = 1'b0;
      for (int i = 0; i < k; i++) begin
         @(negedge clock);
         check("idle_valid", 32'(out_valid), 0);
         check("idle_busy", 32'(decompressor_busy), 0);
      end
   endtask

   // Called between a negedge and the next posedge with busy low.
   task automatic send(input logic cw, input logic [15:0] d,
                       input bit noisy);
      int n;
      model_item(cw, d);
      n = exp_q.size();
      data_in         = d;
      control_word_in = cw;
      data_in_valid   = 1'b1;
      for (int i = 0; i < n; i++) begin
         @(negedge clock);
         check("out_valid", 32'(out_valid), 1);
         check("busy", 32'(decompressor_busy), 1);
         check("byte", 32'(decompressed_byte),
               32'(exp_q.pop_front()));
         if (noisy && i < n - 1) scramble();
         if (i == n - 1) data_in_valid = 1'b0;
      end
      @(negedge clock);
      check("end_valid", 32'(out_valid), 0);
      check("end_busy", 32'(decompressor_busy), 0);
   endtask

   initial begin
      reset           = 1'b1;
      data_in         = '0;
      control_word_in = 1'b0;
      data_in_valid   = 1'b0;
      model_reset();
      #2 reset = 1'b0;
      #1;
      check("rst_valid", 32'(out_valid), 0);
      check("rst_busy", 32'(decompressor_busy), 0);
      check("rst_byte", 32'(decompressed_byte), 0);
      @(negedge clock);
      reset = 1'b1;
      idle(2);

      send(1'b0, 16'h0041, 1'b0);
      send(1'b0, 16'h0061, 1'b0);
      send(1'b0, 16'h0062, 1'b0);
      send(1'b0, 16'h0063, 1'b0);
      send(1'b1, 16'h0003, 1'b0);

      send(1'b0, 16'h0078, 1'b0);
      send(1'b1, 16'h0F01, 1'b1);
      idle(2);

      for (int i = 0; i < 300; i++)
         send(1'b0, 16'(i % 256), 1'b0);
      send(1'b1, 16'h00FF, 1'b0);

      send(1'b1, 16'h0000, 1'b0);
      send(1'b1, 16'hF205, 1'b1);

      for (int i = 0; i < 150; i++) begin
         idle($urandom_range(0, 2));
         send(1'($urandom), 16'($urandom), 1'b1);
      end

      send(1'b0, 16'h0078, 1'b0);
      data_in         = 16'h0F01;
      control_word_in = 1'b1;
      data_in_valid   = 1'b1;
      for (int i = 0; i < 4; i++) begin
         @(negedge clock);
         check("mid_valid", 32'(out_valid), 1);
         data_in_valid = 1'b0;
      end
      @(posedge clock);
      #2 reset = 1'b0;
      #1;
      check("mid_rst_valid", 32'(out_valid), 0);
      check("mid_rst_busy", 32'(decompressor_busy), 0);
      check("mid_rst_byte", 32'(decompressed_byte), 0);
      model_reset();
      @(negedge clock);
      reset = 1'b1;
      idle(2);
      send(1'b0, 16'h0042, 1'b0);
      idle(3);
      send(1'b1, 16'h0002, 1'b0);
      send(1'b1, 16'h0001, 1'b0);
      idle(2);

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/lzrw1_decompressor_top.md
# lzrw1_decompressor_top

Streaming LZRW1 decompressor core. Upstream logic presents one compressed item per handshake: a literal byte or a 16-bit copy item, tagged by its control-word bit. The block emits the reconstructed byte stream one byte per cycle. It keeps a circular history of the most recent HISTORY_SIZE output bytes, which copy items read from.

## Interface
- HISTORY_SIZE, default 256: history depth in bytes.
  - Power of two, at most 4096.
  - Pointer width is log2(HISTORY_SIZE).
- clock  in  1  sole clock; all state updates on its rising edge.
- reset  in  1  asynchronous, active-low reset.
- data_in  in  16  compressed item.
  - Literal: byte in data_in[7:0]; data_in[15:8] ignored.
  - Copy item fields:
    - offset[11:8] = data_in[15:12]
    - length−3 = data_in[11:8]
    - offset[7:0] = data_in[7:0]
- control_word_in  in  1  item type: 0 = literal, 1 = copy.
- data_in_valid  in  1  item present; sampled only when busy is low.
- decompressed_byte  out  8  output byte; registered.
- out_valid  out  1  decompressed_byte is valid this cycle.
- decompressor_busy  out  1  high while an item is being expanded; inputs ignored while high.

## Operation
- History: HISTORY_SIZE×8 register array with asynchronous read, plus write pointer wr_ptr.
  - Every emitted byte is written at wr_ptr, then wr_ptr increments modulo HISTORY_SIZE.
- Source address for a copy: (wr_ptr − offset) modulo HISTORY_SIZE.
  - The offset is truncated to pointer width.
  - Offset 0 reads the entry at wr_ptr (oldest byte); this is defined behavior and needs no special case.
- Copy length is the field value + 3, giving a range of 3..18.
- Overlapping copies (offset < length) must work. Each byte is read after the previous byte is written, so offset 1 repeats the last byte.
- FSM has two states:
  - IDLE (busy=0): if data_in_valid, accept the item.
    - Literal: register the byte as output, write it to history, set remaining=0.
    - Copy: latch offset, emit the first copied byte, set remaining = length−1.
    - Either way, go to EMIT.
  - EMIT (busy=1):
    - If remaining=0: out_valid←0, go to IDLE.
    - Otherwise: emit the next copied byte, remaining−1.
- Unwritten history entries read as 0x00.

## Timing
- Reset (asynchronous assert): the following all go to 0 immediately, and state goes to IDLE:
  - decompressed_byte, out_valid, decompressor_busy
  - wr_ptr, remaining
  - all history entries
- Acceptance edge E0 is the first rising edge where busy=0 and data_in_valid=1.
- Literal:
  - out_valid=1 for exactly one cycle after E0.
  - busy=1 for that same cycle only.
- Copy of length L:
  - out_valid=1 and busy=1 for exactly L consecutive cycles after E0, one byte per cycle.
  - Both drop together.
- Busy falls on the same edge that clears out_valid.
- The earliest next acceptance is the following edge, so there is at least one idle cycle between items.
- Handshake: upstream holds data_in, control_word_in and data_in_valid until busy falls, then presents the next item. Inputs are don't-care while busy=1.
- With data_in_valid held high and busy low, a new item is accepted every idle cycle. The block never emits while idle.
- Reset mid-copy: output stops immediately and the remaining count is discarded. After reset deasserts, the first output comes from a fresh item.

## Test plan
- Literal: reset, then data_in=0x0041, cw=0, valid=1.
  - One cycle later: out_valid=1, byte=0x41, busy=1 for exactly one cycle.
- Copy: literals 'a','b','c', then copy data_in=0x0003 (offset 3, len 3).
  - Output is "abcabc"; busy high 3 cycles on the copy.
- Overlap: literal 'x', then copy data_in=0x0F01 (offset 1, len 18).
  - Output is 19 consecutive 'x', out_valid contiguous for 18 cycles.
- Wrap-around: 300 literals with value i mod 256, then copy offset 255 len 3.
  - Output repeats the bytes written 255 positions earlier, read across the pointer wrap.
- Input while busy: change data_in and toggle valid during an 18-byte copy.
  - Output is unaffected; the next item is accepted only after busy falls.
- Reset mid-copy: assert reset during byte 5 of an 18-byte copy.
  - out_valid and busy go to 0 immediately.
  - A subsequent literal 0x42 outputs 0x42 only.
